vga_fb_arbiter: RTL and testbench

Frame-buffer access scheduler for the 640x480 VGA path. It shares one single-port pixel memory between two users: display fetch, which streams pixels in raster order into a small prefetch FIFO, and a drawing writer. The display pipeline pops pixels at pixel rate; any leftover memory slots go to the writer. It sits between the frame-buffer RAM and the VGA timing/colour stage.

---
 rtl/vga_fb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer access scheduler: shares one single-port pixel RAM between
// raster-order display fetch (into a small prefetch FIFO) and a drawing writer.
module vga_fb_arbiter #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOW_WATER  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [5:0]        pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [5:0]        mem_wdata,
    input  logic [5:0]        mem_rdata
);

    localparam int unsigned NPIX = H_VISIBLE * V_VISIBLE;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [CW:0]       DEPTH_L   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW:0]       LOW_L     = (CW + 1)'(LOW_WATER);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic              rd_p1_q, rd_p2_q;   // read issued 1 / 2 cycles ago, data not yet in FIFO
    logic [5:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic [CW:0] level;
    logic        wr_elig;
    logic        rd_grant, wr_grant;
    logic        push, pop;

    assign level   = {1'b0, count_q} + (CW + 1)'(rd_p1_q) + (CW + 1)'(rd_p2_q);
    // Masking in the ack cycle stops the still-held request from being granted twice.
    assign wr_elig = wr_req && !wr_ack;
    // frame_start flushes the FIFO, so nothing is pushed or popped in that cycle.
    assign push    = rd_p2_q && !frame_start;
    assign pop     = pix_req && (count_q != '0) && !frame_start;

    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_ptr_q] : 6'b0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: frame_start always restarts; last fetch issue ends the frame.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = StActive;
        end else if (state_q == StActive && rd_grant && fetch_addr_q == LAST_ADDR) begin
            state_d = StDone;
        end
    end

    // Arbitration decision: display first unless comfortably filled and writer waiting.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!frame_start && state_q == StActive && level < DEPTH_L &&
            (level < LOW_L || !wr_elig)) begin
            rd_grant = 1'b1;
        end else if (wr_elig) begin
            wr_grant = 1'b1;
        end
    end

    // Registered memory strobes, write acknowledge and fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wr_ack       <= 1'b0;
            fetch_addr_q <= '0;
        end else begin
            mem_en <= rd_grant || wr_grant;
            mem_we <= wr_grant;
            wr_ack <= wr_grant;
            if (rd_grant) begin
                mem_addr <= fetch_addr_q;
            end else if (wr_grant) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            if (frame_start) begin
                fetch_addr_q <= '0;
            end else if (rd_grant) begin
                fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
            end
        end
    end

    // In-flight read tracking; clearing it on frame_start discards stale returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1_q <= 1'b0;
            rd_p2_q <= 1'b0;
        end else if (frame_start) begin
            rd_p1_q <= 1'b0;
            rd_p2_q <= 1'b0;
        end else begin
            rd_p1_q <= rd_grant;
            rd_p2_q <= rd_p1_q;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (frame_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count so need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    // Underflow pulse one cycle after a request against an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else begin
            underflow <= pix_req && (count_q == '0);
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: cycle vector table plus corner sequences.
module tb_vga_fb_arbiter;

    localparam int unsigned H    = 16;
    localparam int unsigned V    = 8;
    localparam int unsigned NPIX = H * V;
    localparam int unsigned AW   = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_req = 1'b0;
    logic [5:0]    pix_data;
    logic          pix_valid;
    logic          underflow;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [5:0]    wr_data = '0;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [5:0]    mem_wdata;
    logic [5:0]    mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    vga_fb_arbiter #(
        .H_VISIBLE (H),
        .V_VISIBLE (V),
        .ADDR_W    (AW),
        .FIFO_DEPTH(4),
        .LOW_WATER (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_req    (pix_req),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .underflow  (underflow),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory pattern: contents are a fixed function of the address.
    function automatic logic [5:0] pat(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 5 + 9;
        return t[5:0];
    endfunction

    // Synchronous RAM model: data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        pix_req = 1'b0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          fs, pr, wr;
        logic [AW-1:0] wa;
        logic [5:0]    wd;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [5:0]    wdat;
        logic          ack, pv;
        logic [5:0]    pd;
        logic          uf;
    } vec_t;

    function automatic vec_t mkv(input int fs, input int pr, input int wr, input int wa,
                                 input int wd, input int en, input int we, input int addr,
                                 input int wdat, input int ack, input int pv, input int pd,
                                 input int uf);
        vec_t v;
        v.fs = fs[0];  v.pr = pr[0];  v.wr = wr[0];
        v.wa = wa[AW-1:0];  v.wd = wd[5:0];
        v.en = en[0];  v.we = we[0];  v.addr = addr[AW-1:0];
        v.wdat = wdat[5:0];  v.ack = ack[0];  v.pv = pv[0];
        v.pd = pd[5:0];  v.uf = uf[0];
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int exp_rd;
        int pop_idx;
        int stray;
        logic pr;

        // Startup fill from frame_start, then writer wins against a full FIFO.
        //             fs pr wr wa     wd     en we addr   wdat   ack pv pd  uf
        vecs[0]  = mkv(1, 0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0,  0);
        vecs[1]  = mkv(0, 0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0,  0);
        vecs[2]  = mkv(0, 0, 0, 0,     0,     1, 0, 0,     0,     0, 0, 0,  0);
        vecs[3]  = mkv(0, 0, 0, 0,     0,     1, 0, 1,     0,     0, 0, 0,  0);
        vecs[4]  = mkv(0, 0, 0, 0,     0,     1, 0, 2,     0,     0, 1, 9,  0);
        vecs[5]  = mkv(0, 0, 0, 0,     0,     1, 0, 3,     0,     0, 1, 9,  0);
        vecs[6]  = mkv(0, 0, 0, 0,     0,     0, 0, 3,     0,     0, 1, 9,  0);
        vecs[7]  = mkv(0, 0, 1, 'h100, 'h30,  0, 0, 3,     0,     0, 1, 9,  0);
        vecs[8]  = mkv(0, 0, 1, 'h100, 'h30,  1, 1, 'h100, 'h30,  1, 1, 9,  0);
        vecs[9]  = mkv(0, 0, 1, 'h100, 'h30,  0, 0, 'h100, 'h30,  0, 1, 9,  0);
        vecs[10] = mkv(0, 1, 1, 'h100, 'h30,  1, 1, 'h100, 'h30,  1, 1, 9,  0);
        vecs[11] = mkv(0, 0, 0, 0,     0,     0, 0, 'h100, 'h30,  0, 1, 14, 0);
        vecs[12] = mkv(0, 0, 0, 0,     0,     1, 0, 4,     'h30,  0, 1, 14, 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("v%0d.mem_en", i),    int'(mem_en),    int'(vecs[i].en));
            chk($sformatf("v%0d.mem_we", i),    int'(mem_we),    int'(vecs[i].we));
            chk($sformatf("v%0d.mem_addr", i),  int'(mem_addr),  int'(vecs[i].addr));
            chk($sformatf("v%0d.mem_wdata", i), int'(mem_wdata), int'(vecs[i].wdat));
            chk($sformatf("v%0d.wr_ack", i),    int'(wr_ack),    int'(vecs[i].ack));
            chk($sformatf("v%0d.pix_valid", i), int'(pix_valid), int'(vecs[i].pv));
            chk($sformatf("v%0d.pix_data", i),  int'(pix_data),  int'(vecs[i].pd));
            chk($sformatf("v%0d.underflow", i), int'(underflow), int'(vecs[i].uf));
            frame_start = vecs[i].fs;
            pix_req     = vecs[i].pr;
            wr_req      = vecs[i].wr;
            wr_addr     = vecs[i].wa;
            wr_data     = vecs[i].wd;
            step();
        end

        // Underflow: request against an empty FIFO pulses underflow for one cycle.
        do_reset();
        chk("uf_before", int'(underflow), 0);
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        chk("uf_pulse", int'(underflow), 1);
        chk("uf_pix_valid", int'(pix_valid), 0);
        chk("uf_pix_data", int'(pix_data), 0);
        step();
        chk("uf_cleared", int'(underflow), 0);

        // frame_start with 2 FIFO entries and 2 reads in flight.
        do_reset();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (4) step();
        chk("fl_pre_valid", int'(pix_valid), 1);
        chk("fl_pre_en", int'(mem_en), 1);
        chk("fl_pre_addr", int'(mem_addr), 3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fl_c6_valid", int'(pix_valid), 0);
        chk("fl_c6_en", int'(mem_en), 0);
        step();
        chk("fl_c7_valid", int'(pix_valid), 0);
        chk("fl_c7_en", int'(mem_en), 1);
        chk("fl_c7_addr", int'(mem_addr), 0);
        step();
        chk("fl_c8_valid", int'(pix_valid), 0);
        chk("fl_c8_addr", int'(mem_addr), 1);
        step();
        chk("fl_c9_valid", int'(pix_valid), 1);
        chk("fl_c9_data", int'(pix_data), int'(pat(0)));
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        chk("fl_c10_data", int'(pix_data), int'(pat(1)));

        // Full frame with a pop every second cycle, then writer-only service.
        do_reset();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        exp_rd = 0;
        pop_idx = 0;
        for (int k = 0; k < 4000; k++) begin
            if (mem_en && !mem_we) begin
                chk("ff_rd_addr", int'(mem_addr), exp_rd);
                exp_rd++;
            end
            pr = (k % 2 == 1) && (pop_idx < int'(NPIX));
            if (pr && pix_valid) begin
                chk("ff_pix_data", int'(pix_data), int'(pat(AW'(pop_idx))));
                pop_idx++;
            end
            pix_req = pr;
            step();
            if (pop_idx == int'(NPIX) && exp_rd == int'(NPIX)) break;
        end
        pix_req = 1'b0;
        chk("ff_reads", exp_rd, int'(NPIX));
        chk("ff_pops", pop_idx, int'(NPIX));
        wr_req  = 1'b1;
        wr_addr = AW'(7);
        wr_data = 6'h05;
        stray = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("done_ack%0d", i), int'(wr_ack), i % 2);
            if (mem_en && !mem_we) stray++;
        end
        wr_req = 1'b0;
        chk("done_no_reads", stray, 0);

        // Asynchronous reset while a write strobe is out.
        do_reset();
        wr_req  = 1'b1;
        wr_addr = AW'('h55);
        wr_data = 6'h2a;
        step();
        chk("rs_we_before", int'(mem_we), 1);
        #2;
        rst = 1'b1;
        wr_req = 1'b0;
        #1;
        chk("rs_mem_en", int'(mem_en), 0);
        chk("rs_mem_we", int'(mem_we), 0);
        chk("rs_mem_addr", int'(mem_addr), 0);
        chk("rs_mem_wdata", int'(mem_wdata), 0);
        chk("rs_wr_ack", int'(wr_ack), 0);
        chk("rs_pix_valid", int'(pix_valid), 0);
        chk("rs_pix_data", int'(pix_data), 0);
        chk("rs_underflow", int'(underflow), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rs_idle%0d", i), int'(mem_en), 0);
        end
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        chk("rs_retry_ack", int'(wr_ack), 1);
        chk("rs_retry_addr", int'(mem_addr), 'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
